// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared types and truth-table constants for the gate tester
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_PATTERNS = 4;

    // Bit i is the expected F for {A,B} = i
    localparam logic [NUM_PATTERNS-1:0] EXP_AND  = 4'b1000;
    localparam logic [NUM_PATTERNS-1:0] EXP_OR   = 4'b1110;
    localparam logic [NUM_PATTERNS-1:0] EXP_XOR  = 4'b0110;
    localparam logic [NUM_PATTERNS-1:0] EXP_NAND = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter with zero flag for the settle wait
module settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over decrement; the counter parks at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tester.sv
// rtl/gate_tester.sv - drives all A/B patterns into a 2-input gate and checks F
module gate_tester
    import gate_test_pkg::*;
#(
    parameter logic [3:0] EXPECT = 4'b1000,
    parameter int         SETTLE = 2,
    parameter int         ERR_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             F,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    localparam int         TW       = $clog2(SETTLE) + 1;
    localparam logic [TW-1:0] RELOAD = TW'(SETTLE - 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_PATTERNS - 1);

    state_e           state_q;
    logic [1:0]       idx_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic [3:0]       fail_q;
    logic             accept;
    logic             mismatch;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;

    // Start is only honoured when no run is in progress
    assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign mismatch = (F != EXPECT[idx_q]);
    // Saturating increment of the error counter
    assign err_d    = (err_q == '1) ? err_q : err_q + 1'b1;
    // Reload the settle wait whenever A/B are about to change to a new pattern
    assign tmr_load = accept || ((state_q == CHECK) && (idx_q != LAST_IDX));
    assign tmr_dec  = (state_q == WAIT);

    settle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (RELOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Run sequencer with registered pattern, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= WAIT;
                        idx_q   <= 2'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= 4'd0;
                    end
                end
                WAIT: begin
                    if (tmr_zero) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_q[idx_q] <= 1'b1;
                        err_q         <= err_d;
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_q      <= idx_q + 2'd1;
                        {a_q, b_q} <= idx_q + 2'd1;
                        state_q    <= WAIT;
                    end else begin
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;
    assign pass     = done_q && (err_q == '0);

endmodule

// File: tb/tb_gate_tester.sv
// tb/tb_gate_tester.sv - directed self-checking bench for gate_tester
module tb_gate_tester;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start_s1;
    logic       start_w1;
    int         mode;
    int         total;
    int         bad;

    logic       a, b, f;
    logic       busy, done, pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    logic       s1_a, s1_b, s1_f, s1_busy, s1_done, s1_pass;
    logic [2:0] s1_err;
    logic [3:0] s1_fail;

    logic       w1_a, w1_b, w1_f, w1_busy, w1_done, w1_pass;
    logic [0:0] w1_err;
    logic [3:0] w1_fail;

    // mode 0: AND gate, 1: OR gate, 2: F stuck at 1
    always_comb begin
        case (mode)
            0:       f = a & b;
            1:       f = a | b;
            default: f = 1'b1;
        endcase
    end
    assign s1_f = s1_a & s1_b;
    assign w1_f = 1'b1;

    gate_tester #(.EXPECT(4'b1000), .SETTLE(2), .ERR_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .F(f),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    gate_tester #(.EXPECT(4'b1000), .SETTLE(1), .ERR_W(3)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_s1), .A(s1_a), .B(s1_b), .F(s1_f),
        .busy(s1_busy), .done(s1_done), .pass(s1_pass), .err_cnt(s1_err), .fail_vec(s1_fail)
    );

    gate_tester #(.EXPECT(4'b1000), .SETTLE(2), .ERR_W(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_w1), .A(w1_a), .B(w1_b), .F(w1_f),
        .busy(w1_busy), .done(w1_done), .pass(w1_pass), .err_cnt(w1_err), .fail_vec(w1_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one accept edge; returns 1 ns after that edge
    task automatic pulse_start();
        start = 1'b1;
        edges(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; mode = 0;
        start = 0; start_s1 = 0; start_w1 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_ab",   {a, b}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err",  err_cnt, 3'd0);
        chk("rst_fail", fail_vec, 4'd0);
        edges(1);
        rst_n = 1'b1;
        edges(2);

        // Run 1: correct AND on all instances sharing edge 0
        start = 1; start_s1 = 1; start_w1 = 1;
        edges(1);
        start = 0; start_s1 = 0; start_w1 = 0;
        chk("and_e0_ab",   {a, b}, 2'b00);
        chk("and_e0_busy", busy, 1'b1);
        chk("s1_e0_busy",  s1_busy, 1'b1);
        edges(2);
        chk("s1_e2_ab",    {s1_a, s1_b}, 2'b01);
        chk("and_e2_ab",   {a, b}, 2'b00);
        edges(1);
        chk("and_e3_ab",   {a, b}, 2'b01);
        edges(1);
        chk("s1_e4_ab",    {s1_a, s1_b}, 2'b10);
        edges(2);
        chk("and_e6_ab",   {a, b}, 2'b10);
        chk("s1_e6_ab",    {s1_a, s1_b}, 2'b11);
        edges(1);
        chk("s1_e7_done",  s1_done, 1'b0);
        edges(1);
        chk("s1_e8_done",  s1_done, 1'b1);
        chk("s1_e8_busy",  s1_busy, 1'b0);
        chk("s1_e8_pass",  s1_pass, 1'b1);
        chk("s1_e8_fail",  s1_fail, 4'd0);
        edges(1);
        chk("and_e9_ab",   {a, b}, 2'b11);
        edges(2);
        chk("and_e11_busy", busy, 1'b1);
        chk("and_e11_done", done, 1'b0);
        edges(1);
        chk("and_e12_done", done, 1'b1);
        chk("and_e12_busy", busy, 1'b0);
        chk("and_e12_pass", pass, 1'b1);
        chk("and_e12_err",  err_cnt, 3'd0);
        chk("and_e12_fail", fail_vec, 4'd0);
        chk("and_e12_ab",   {a, b}, 2'b00);
        chk("w1_e12_done",  w1_done, 1'b1);
        chk("w1_e12_err",   w1_err, 1'b1);
        chk("w1_e12_fail",  w1_fail, 4'b0111);
        chk("w1_e12_pass",  w1_pass, 1'b0);
        edges(3);
        chk("and_hold_done", done, 1'b1);

        // Run 2: OR gate against AND table
        mode = 1;
        pulse_start();
        chk("or_e0_done", done, 1'b0);
        chk("or_e0_busy", busy, 1'b1);
        edges(12);
        chk("or_done", done, 1'b1);
        chk("or_fail", fail_vec, 4'b0110);
        chk("or_err",  err_cnt, 3'd2);
        chk("or_pass", pass, 1'b0);

        // Run 3: F stuck high, restart from DONE clears results, busy starts ignored
        mode = 2;
        pulse_start();
        chk("st_e0_err",  err_cnt, 3'd0);
        chk("st_e0_fail", fail_vec, 4'd0);
        chk("st_e0_done", done, 1'b0);
        edges(2);
        pulse_start();
        chk("st_e3_ab",   {a, b}, 2'b01);
        chk("st_e3_busy", busy, 1'b1);
        edges(3);
        pulse_start();
        chk("st_e7_ab",   {a, b}, 2'b10);
        edges(4);
        chk("st_e11_done", done, 1'b0);
        edges(1);
        chk("st_done", done, 1'b1);
        chk("st_fail", fail_vec, 4'b0111);
        chk("st_err",  err_cnt, 3'd3);
        chk("st_pass", pass, 1'b0);

        // Run 4: reset during pattern 2 wait
        pulse_start();
        edges(7);
        chk("mr_pre_ab",  {a, b}, 2'b10);
        chk("mr_pre_err", err_cnt, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("mr_ab",   {a, b}, 2'b00);
        chk("mr_busy", busy, 1'b0);
        chk("mr_done", done, 1'b0);
        chk("mr_err",  err_cnt, 3'd0);
        chk("mr_fail", fail_vec, 4'd0);
        rst_n = 1'b1;
        edges(2);
        chk("mr_idle_busy", busy, 1'b0);
        mode = 0;
        pulse_start();
        edges(11);
        chk("mr_e11_done", done, 1'b0);
        edges(1);
        chk("mr_e12_done", done, 1'b1);
        chk("mr_e12_pass", pass, 1'b1);

        // Run 5: start held high gives back-to-back runs with one DONE cycle between
        start = 1'b1;
        edges(13);
        chk("bb_e12_done", done, 1'b1);
        chk("bb_e12_busy", busy, 1'b0);
        edges(1);
        start = 1'b0;
        chk("bb_e13_done", done, 1'b0);
        chk("bb_e13_busy", busy, 1'b1);
        edges(12);
        chk("bb_e25_done", done, 1'b1);
        chk("bb_e25_pass", pass, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
